// File: rtl/c_wrap_counter.sv
// Registered range counter over [min_value, max_value] with variable step,
// parallel load and wrap-around or saturating arithmetic.
module c_wrap_counter #(
    parameter int width       = 4,
    parameter int min_value   = 4,
    parameter int max_value   = 7,
    parameter int reset_value = min_value,
    parameter int step_width  = 2,
    parameter int saturate    = 0
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  active_i,
    input  logic                  load_i,
    input  logic [width-1:0]      load_value_i,
    input  logic                  incr_i,
    input  logic                  decr_i,
    input  logic [step_width-1:0] step_i,
    output logic [width-1:0]      value_o,
    output logic                  at_min_o,
    output logic                  at_max_o,
    output logic                  wrap_o,
    output logic                  error_o
);

    localparam int RANGE = max_value - min_value + 1;

    localparam logic [width:0]   MIN_X   = (width+1)'(min_value);
    localparam logic [width:0]   MAX_X   = (width+1)'(max_value);
    localparam logic [width:0]   RANGE_X = (width+1)'(RANGE);
    localparam logic [width-1:0] MIN_V   = width'(min_value);
    localparam logic [width-1:0] MAX_V   = width'(max_value);
    localparam logic [width-1:0] RST_V   = width'(reset_value);

    if (min_value < 0 || min_value > max_value || max_value >= (1 << width)) begin : g_bad_range
        $error("c_wrap_counter: illegal min_value/max_value");
    end
    if (reset_value < min_value || reset_value > max_value) begin : g_bad_reset
        $error("c_wrap_counter: reset_value outside [min_value, max_value]");
    end
    if (((1 << step_width) - 1) > RANGE) begin : g_bad_step
        $error("c_wrap_counter: step_width too large for the counter range");
    end

    logic [width-1:0] value_q, value_d;
    logic             wrap_q, wrap_d;
    logic             error_q, error_d;

    logic [width:0] val_x, step_x, sum_x, load_x;
    logic           under;

    always_comb begin
        val_x   = {1'b0, value_q};
        step_x  = (width+1)'(step_i);
        load_x  = {1'b0, load_value_i};
        sum_x   = val_x + step_x;
        // value - step < min, rearranged so nothing goes negative
        under   = val_x < (MIN_X + step_x);
        value_d = value_q;
        wrap_d  = wrap_q;
        error_d = error_q;
        if (active_i) begin
            if (load_i) begin
                wrap_d = 1'b0;
                if (load_x >= MIN_X && load_x <= MAX_X) begin
                    value_d = load_value_i;
                end else begin
                    error_d = 1'b1;
                end
            end else if ((incr_i ^ decr_i) && (step_i != '0)) begin
                if (incr_i) begin
                    if (sum_x > MAX_X) begin
                        wrap_d  = 1'b1;
                        value_d = (saturate != 0) ? MAX_V : width'(sum_x - RANGE_X);
                    end else begin
                        wrap_d  = 1'b0;
                        value_d = width'(sum_x);
                    end
                end else begin
                    if (under) begin
                        wrap_d  = 1'b1;
                        value_d = (saturate != 0) ? MIN_V : width'(val_x + RANGE_X - step_x);
                    end else begin
                        wrap_d  = 1'b0;
                        value_d = width'(val_x - step_x);
                    end
                end
            end else begin
                wrap_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            value_q <= RST_V;
            wrap_q  <= 1'b0;
            error_q <= 1'b0;
        end else begin
            value_q <= value_d;
            wrap_q  <= wrap_d;
            error_q <= error_d;
        end
    end

    assign value_o  = value_q;
    assign at_min_o = (value_q == MIN_V);
    assign at_max_o = (value_q == MAX_V);
    assign wrap_o   = wrap_q;
    assign error_o  = error_q;

endmodule

// File: tb/tb_c_wrap_counter.sv
// Bench for c_wrap_counter: a wrap-mode and a saturate-mode instance share stimulus
// and are compared each cycle against a modular-arithmetic reference model.
module tb_c_wrap_counter;

    localparam int MINV = 4;
    localparam int MAXV = 7;
    localparam int RNG  = MAXV - MINV + 1;

    logic       clk = 1'b0;
    logic       rst, act, ld, inc, dec;
    logic [3:0] lv;
    logic [1:0] st;

    logic [1:0][3:0] dv;
    logic [1:0]      dmin, dmax, dwrap, derr;

    int n_tests = 0;
    int n_fail  = 0;

    // model state, index 0 = wrap instance, 1 = saturate instance
    int mv[2];
    int mw[2];
    int me[2];

    always #5 clk = ~clk;

    c_wrap_counter #(.width(4), .min_value(4), .max_value(7), .reset_value(4),
                     .step_width(2), .saturate(0)) dut_w (
        .clk_i(clk), .reset_i(rst), .active_i(act), .load_i(ld), .load_value_i(lv),
        .incr_i(inc), .decr_i(dec), .step_i(st), .value_o(dv[0]), .at_min_o(dmin[0]),
        .at_max_o(dmax[0]), .wrap_o(dwrap[0]), .error_o(derr[0]));

    c_wrap_counter #(.width(4), .min_value(4), .max_value(7), .reset_value(4),
                     .step_width(2), .saturate(1)) dut_s (
        .clk_i(clk), .reset_i(rst), .active_i(act), .load_i(ld), .load_value_i(lv),
        .incr_i(inc), .decr_i(dec), .step_i(st), .value_o(dv[1]), .at_min_o(dmin[1]),
        .at_max_o(dmax[1]), .wrap_o(dwrap[1]), .error_o(derr[1]));

    typedef struct {
        logic       rst, act, ld;
        logic [3:0] lv;
        logic       inc, dec;
        logic [1:0] st;
        int         ev, ew, ee;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic r, a, l, input int v, input logic i, d,
                                input int s, input int ev, ew, ee);
        vec_t x;
        x.rst = r; x.act = a; x.ld = l; x.lv = 4'(v); x.inc = i; x.dec = d;
        x.st = 2'(s); x.ev = ev; x.ew = ew; x.ee = ee;
        return x;
    endfunction

    task automatic chk(input string nm, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, got, exp);
        end
    endtask

    // Next state from the rules: position within the range, modulo the range size.
    task automatic model_next(input int sat, input int v, w, e, output int nv, nw, ne);
        int t;
        nv = v; nw = w; ne = e;
        if (rst) begin
            nv = MINV; nw = 0; ne = 0;
        end else if (act) begin
            if (ld) begin
                nw = 0;
                if (int'(lv) >= MINV && int'(lv) <= MAXV) nv = int'(lv);
                else ne = 1;
            end else if (inc != dec && st != 0) begin
                t = v - MINV + (inc ? int'(st) : -int'(st));
                if (t < 0 || t >= RNG) begin
                    nw = 1;
                    if (sat != 0) nv = (t < 0) ? MINV : MAXV;
                    else          nv = MINV + (((t % RNG) + RNG) % RNG);
                end else begin
                    nw = 0;
                    nv = MINV + t;
                end
            end else begin
                nw = 0;
            end
        end
    endtask

    task automatic cycle();
        int nv[2], nw[2], ne[2];
        for (int k = 0; k < 2; k++) model_next(k, mv[k], mw[k], me[k], nv[k], nw[k], ne[k]);
        @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            mv[k] = nv[k]; mw[k] = nw[k]; me[k] = ne[k];
        end
    endtask

    task automatic chk_model(input string tag);
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("%s model value[%0d]", tag, k), int'(dv[k]), mv[k]);
            chk($sformatf("%s model wrap[%0d]", tag, k), int'(dwrap[k]), mw[k]);
            chk($sformatf("%s model error[%0d]", tag, k), int'(derr[k]), me[k]);
            chk($sformatf("%s model at_min[%0d]", tag, k), int'(dmin[k]), int'(mv[k] == MINV));
            chk($sformatf("%s model at_max[%0d]", tag, k), int'(dmax[k]), int'(mv[k] == MAXV));
        end
    endtask

    task automatic drive(input logic r, a, l, input int v, input logic i, d, input int s);
        rst = r; act = a; ld = l; lv = 4'(v); inc = i; dec = d; st = 2'(s);
        cycle();
    endtask

    initial begin
        rst = 1'b0; act = 1'b0; ld = 1'b0; lv = '0; inc = 1'b0; dec = 1'b0; st = '0;
        for (int k = 0; k < 2; k++) begin
            mv[k] = MINV; mw[k] = 0; me[k] = 0;
        end

        // rst act ld lv inc dec st | value wrap error (wrap-mode instance)
        tbl.push_back(mk(1, 1, 0, 0, 1, 0, 1, 4, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 1, 0, 1, 5, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 1, 0, 1, 6, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 1, 0, 1, 7, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 1, 0, 1, 4, 1, 0));
        tbl.push_back(mk(0, 1, 1, 5, 0, 0, 0, 5, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 0, 1, 3, 6, 1, 0));
        tbl.push_back(mk(0, 1, 0, 0, 0, 1, 2, 4, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 0, 1, 1, 7, 1, 0));
        tbl.push_back(mk(0, 1, 0, 0, 0, 1, 1, 6, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 0, 1, 1, 5, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 0, 1, 1, 4, 0, 0));
        tbl.push_back(mk(0, 1, 1, 7, 0, 0, 0, 7, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 1, 0, 3, 6, 1, 0));
        tbl.push_back(mk(0, 1, 0, 0, 1, 0, 3, 5, 1, 0));
        tbl.push_back(mk(0, 1, 0, 0, 1, 0, 0, 5, 0, 0));
        tbl.push_back(mk(0, 1, 1, 9, 0, 0, 0, 5, 0, 1));
        tbl.push_back(mk(0, 1, 1, 6, 0, 0, 0, 6, 0, 1));
        tbl.push_back(mk(1, 1, 0, 0, 1, 0, 1, 4, 0, 0));
        tbl.push_back(mk(0, 0, 1, 9, 0, 0, 0, 4, 0, 0));
        tbl.push_back(mk(0, 1, 1, 6, 1, 0, 1, 6, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 1, 1, 1, 6, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 1, 0, 1, 6, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 1, 0, 1, 6, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 1, 0, 1, 6, 0, 0));
        tbl.push_back(mk(1, 1, 0, 0, 1, 0, 1, 4, 0, 0));
        tbl.push_back(mk(0, 1, 1, 7, 0, 0, 0, 7, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 1, 0, 1, 4, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 1, 0, 1, 4, 1, 0));
        tbl.push_back(mk(0, 1, 0, 0, 1, 0, 1, 5, 0, 0));

        foreach (tbl[n]) begin
            drive(tbl[n].rst, tbl[n].act, tbl[n].ld, int'(tbl[n].lv), tbl[n].inc,
                  tbl[n].dec, int'(tbl[n].st));
            chk($sformatf("vec%0d value", n), int'(dv[0]), tbl[n].ev);
            chk($sformatf("vec%0d wrap", n), int'(dwrap[0]), tbl[n].ew);
            chk($sformatf("vec%0d error", n), int'(derr[0]), tbl[n].ee);
            chk($sformatf("vec%0d at_min", n), int'(dmin[0]), int'(tbl[n].ev == MINV));
            chk($sformatf("vec%0d at_max", n), int'(dmax[0]), int'(tbl[n].ev == MAXV));
            chk_model($sformatf("vec%0d", n));
        end

        // saturating corner cases on the saturate instance
        drive(0, 1, 1, 6, 0, 0, 0);
        drive(0, 1, 0, 0, 1, 0, 3);
        chk("sat incr clamp value", int'(dv[1]), 7);
        chk("sat incr clamp wrap", int'(dwrap[1]), 1);
        drive(0, 1, 1, 5, 0, 0, 0);
        drive(0, 1, 0, 0, 0, 1, 3);
        chk("sat decr clamp value", int'(dv[1]), 4);
        chk("sat decr clamp wrap", int'(dwrap[1]), 1);
        drive(0, 1, 1, 7, 0, 0, 0);
        drive(0, 1, 0, 0, 1, 0, 0);
        chk("sat step0 value", int'(dv[1]), 7);
        chk("sat step0 wrap", int'(dwrap[1]), 0);
        drive(0, 1, 0, 0, 1, 0, 1);
        chk("sat at max value", int'(dv[1]), 7);
        chk("sat at max wrap", int'(dwrap[1]), 1);
        chk_model("sat");

        for (int n = 0; n < 400; n++) begin
            drive(($urandom_range(31) == 0), ($urandom_range(7) != 0),
                  ($urandom_range(5) == 0), int'($urandom_range(15)),
                  1'($urandom_range(1)), 1'($urandom_range(1)), int'($urandom_range(3)));
            chk_model($sformatf("rand%0d", n));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
